// File: rtl/add_disp_pkg.sv
// -----------------------------------------------------------------------------
// add_disp_pkg
// Shared definitions for the adder + 4-digit multiplexed 7-segment display.
//   state_e      : controller states (BLANK until the first load, then SCAN)
//   SEG_0..SEG_F : active-low segment patterns, bit order {a,b,c,d,e,f,g}
//   SEG_BLANK    : all segments off
//   AN_OFF       : all anodes disabled
//   hex_to_seg() : 4-bit value to segment pattern lookup
// -----------------------------------------------------------------------------
package add_disp_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_e;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex.sv
// -----------------------------------------------------------------------------
// seg7_hex
// Hex digit to active-low 7-segment decoder (purely combinational).
//   value_i [3:0] : digit value 0..F
//   seg_o   [6:0] : segment pattern {a,b,c,d,e,f,g}, 0 = lit
// -----------------------------------------------------------------------------
module seg7_hex
    import add_disp_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(value_i);

endmodule

// File: rtl/add_disp_scan.sv
// -----------------------------------------------------------------------------
// add_disp_scan
// Captures two 4-bit operands on load, registers their 5-bit sum and scans it
// across a 4-digit common-anode display:
//   digit 3 = a_q (hex), digit 2 = b_q (hex), digit 1 = sum tens (blanked when
//   zero), digit 0 = sum units, decimal point on digit 0 flags the carry out.
// Each digit slot lasts REFRESH_DIV cycles; the first cycle of every slot is
// dark so the previous digit's segments never bleed onto the next anode.
//
// Ports
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset, dominates load
//   a, b [3:0]  : operands, sampled only when load=1
//   load        : single-cycle capture strobe
//   seg  [6:0]  : active-low segments {a..g}
//   an   [3:0]  : active-low anode enables, an[0] = rightmost digit
//   dp          : active-low decimal point
//   sum_q[4:0]  : registered a_q + b_q
//   busy        : high while scanning
//
// State | meaning
// ------+-------------------------------------------------------------
// BLANK | no load seen since reset; display dark
// SCAN  | operands valid; refresh counter and digit index running
// -----------------------------------------------------------------------------
module add_disp_scan
    import add_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic [4:0] sum_q,
    output logic       busy
);

    localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic [4:0]  sum_d;

    logic [1:0]  tens;
    logic [3:0]  ones;
    logic [4:0]  ones_wide;
    logic [3:0]  digit_val;
    logic        digit_blank;
    logic [6:0]  digit_seg;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;

        if (load) begin
            a_d   = a;
            b_d   = b;
            sum_d = {1'b0, a} + {1'b0, b};
        end

        case (state_q)
            ST_BLANK: begin
                if (load) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                // A load here only refreshes the operands; the scan keeps going.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // ---------------- decimal split (sum_q is 0..30) ----------------
    always_comb begin
        tens      = 2'd0;
        ones_wide = sum_q;
        if (sum_q >= 5'd30) begin
            tens      = 2'd3;
            ones_wide = sum_q - 5'd30;
        end else if (sum_q >= 5'd20) begin
            tens      = 2'd2;
            ones_wide = sum_q - 5'd20;
        end else if (sum_q >= 5'd10) begin
            tens      = 2'd1;
            ones_wide = sum_q - 5'd10;
        end
        ones = ones_wide[3:0];
    end

    // ---------------- digit mux ----------------
    always_comb begin
        digit_val   = ones;
        digit_blank = 1'b0;
        case (idx_q)
            2'd0: digit_val = ones;
            2'd1: begin
                digit_val   = {2'b00, tens};
                digit_blank = (tens == 2'd0);
            end
            2'd2: digit_val = b_q;
            default: digit_val = a_q;
        endcase
    end

    seg7_hex u_seg7_hex (
        .value_i (digit_val),
        .seg_o   (digit_seg)
    );

    // ---------------- display outputs (registered state only) ----------------
    always_comb begin
        an  = AN_OFF;
        seg = SEG_BLANK;
        dp  = 1'b1;
        if (state_q == ST_SCAN && cnt_q != 16'd0) begin
            an  = ~(4'b0001 << idx_q);
            seg = digit_blank ? SEG_BLANK : digit_seg;
            dp  = ~((idx_q == 2'd0) & sum_q[4]);
        end
    end

    assign busy = (state_q == ST_SCAN);

endmodule

// File: tb/tb_add_disp_scan.sv
module tb_add_disp_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       load = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [4:0] sum_q;
    logic       busy;

    add_disp_scan #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .load  (load),
        .seg   (seg),
        .an    (an),
        .dp    (dp),
        .sum_q (sum_q),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // observed/expected vector: {busy, sum_q, an, seg, dp}
    wire [17:0] obs = {busy, sum_q, an, seg, dp};

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] sb[$];
    logic [17:0] exp_v;

    logic [6:0] hex_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // reference model state
    logic       m_scan = 1'b0;
    int         m_cnt  = 0;
    int         m_idx  = 0;
    logic [3:0] m_a    = 4'h0;
    logic [3:0] m_b    = 4'h0;
    logic [4:0] m_sum  = 5'd0;

    function automatic logic [17:0] model_out();
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        int         t;
        an_e  = 4'b1111;
        seg_e = 7'b1111111;
        dp_e  = 1'b1;
        if (m_scan && m_cnt != 0) begin
            an_e = 4'b1111;
            an_e[m_idx] = 1'b0;
            t = int'(m_sum) / 10;
            case (m_idx)
                0: seg_e = hex_tbl[int'(m_sum) % 10];
                1: seg_e = (t == 0) ? 7'b1111111 : hex_tbl[t];
                2: seg_e = hex_tbl[m_b];
                default: seg_e = hex_tbl[m_a];
            endcase
            if (m_idx == 0 && m_sum > 5'd15) dp_e = 1'b0;
        end
        return {m_scan, m_sum, an_e, seg_e, dp_e};
    endfunction

    // Drive one cycle of stimulus, advance the model across the edge and push
    // the expected outputs; the caller pops and compares at the falling edge.
    task automatic tick(input logic r, input logic l, input logic [3:0] av, input logic [3:0] bv);
        rst  = r;
        load = l;
        a    = av;
        b    = bv;
        @(posedge clk);
        if (r) begin
            m_scan = 1'b0; m_cnt = 0; m_idx = 0;
            m_a = 4'h0; m_b = 4'h0; m_sum = 5'd0;
        end else begin
            if (m_scan) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % 4;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else if (l) begin
                m_scan = 1'b1; m_cnt = 0; m_idx = 0;
            end
            if (l) begin
                m_a = av; m_b = bv;
                m_sum = 5'(int'(av) + int'(bv));
            end
        end
        sb.push_back(model_out());
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 4'h0, 4'h0);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b", obs, exp_v);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 4'h5, 4'hA);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v || obs !== 18'b0_00000_1111_1111111_1) begin
                n_err++;
                $display("FAIL idle_blank cyc %0d: got %b expected %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_load_scan(input logic [3:0] av, input logic [3:0] bv, input int cycles);
        tick(1'b0, 1'b1, av, bv);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL load_%h_%h: got %b expected %b", av, bv, obs, exp_v);
        end
        for (int i = 0; i < cycles; i++) begin
            tick(1'b0, 1'b0, 4'h0, 4'h0);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL scan_%h_%h cyc %0d: got %b expected %b", av, bv, i, obs, exp_v);
            end
        end
    endtask

    task automatic test_sum17();
        // first load from BLANK: slot 0 starts with its dark cycle
        test_load_scan(4'h9, 4'h8, 17);
        n_cmp++;
        if (sum_q !== 5'd17) begin
            n_err++;
            $display("FAIL sum17: got %0d expected 17", sum_q);
        end
    endtask

    task automatic test_load_mid_scan();
        int guard;
        guard = 0;
        while (!(m_idx == 2 && m_cnt == 2) && guard < 64) begin
            tick(1'b0, 1'b0, 4'h0, 4'h0);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL seek_idx2 cyc %0d: got %b expected %b", guard, obs, exp_v);
            end
            guard++;
        end
        if (guard >= 64) begin
            n_err++;
            $display("FAIL seek_idx2 timeout: got idx %0d cnt %0d expected idx 2 cnt 2", m_idx, m_cnt);
        end
        tick(1'b0, 1'b1, 4'h1, 4'hC);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v || an !== 4'b1011 || seg !== 7'b0110001) begin
            n_err++;
            $display("FAIL load_mid_scan: got an %b seg %b (%b) expected an 1011 seg 0110001 (%b)", an, seg, obs, exp_v);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 4'h0, 4'h0);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL after_mid_load cyc %0d: got %b expected %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_with_load();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 4'h0, 4'h0);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL pre_rst cyc %0d: got %b expected %b", i, obs, exp_v);
            end
        end
        tick(1'b1, 1'b1, 4'h7, 4'h7);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v || obs !== 18'b0_00000_1111_1111111_1) begin
            n_err++;
            $display("FAIL rst_over_load: got %b expected %b", obs, exp_v);
        end
        // restart: dark cycle, then idx0 lit for three cycles, then idx1 dark
        test_load_scan(4'h6, 4'h7, 6);
    endtask

    initial begin
        test_reset();
        test_sum17();
        test_load_scan(4'h2, 4'h3, 16);
        test_load_scan(4'hF, 4'hF, 16);
        test_load_mid_scan();
        test_reset_with_load();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
